sync_emitter: RTL and testbench

SYNC_EMITTER -- requirements
Module: sync_emitter

---
 rtl/sync_emitter_pkg.sv | 18 +
 rtl/sync_emitter_if.sv | 12 +
 rtl/sync_emitter_shreg.sv | 40 ++++
 rtl/sync_emitter.sv | 131 +++++++++++++
 tb/tb_sync_emitter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_emitter_pkg.sv
// sync_emitter_pkg: shared FSM state type, counter/code widths and the sync pulse-width rule.
package sync_emitter_pkg;

   typedef enum logic [1:0] {IDLE, SYNC, WAIT} state_t;

   localparam int unsigned CNT_W  = 20;
   localparam int unsigned CODE_W = 3;
   localparam int unsigned DATA_W = 8;

   typedef logic [CODE_W-1:0] code_t;

   function automatic int unsigned pulse_width(input int unsigned base,
                                               input int unsigned step,
                                               input code_t       code);
      return base + step * 32'(code);
   endfunction

endpackage

// File: rtl/sync_emitter_if.sv
// sync_emitter_if: payload byte valid/ready handshake between a byte source and the emitter.
interface sync_emitter_if;
   import sync_emitter_pkg::*;

   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/sync_emitter_shreg.sv
// sync_emitter_shreg: 8-bit MSB-first payload shifter; accepts a byte only while empty.
module sync_emitter_shreg
   import sync_emitter_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_pop,
   output logic          o_bit,
   sync_emitter_if.slave dbus
);

   logic [DATA_W-1:0] r_sr;
   logic [3:0]        r_left;
   logic              r_empty;
   logic              w_load;

   assign w_load = dbus.data_valid && r_empty;

   // A load can only occur while empty, so a pop in the same cycle is an
   // underrun (bit 0) and the freshly loaded byte stays intact.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr    <= '0;
         r_left  <= '0;
         r_empty <= 1'b1;
      end else if (w_load) begin
         r_sr    <= dbus.data_in;
         r_left  <= 4'(DATA_W);
         r_empty <= 1'b0;
      end else if (i_pop && !r_empty) begin
         r_sr    <= {r_sr[DATA_W-2:0], 1'b0};
         r_left  <= r_left - 1'b1;
         r_empty <= (r_left == 4'd1);
      end
   end

   assign o_bit           = r_sr[DATA_W-1] & ~r_empty;
   assign dbus.data_ready = r_empty;

endmodule

// File: rtl/sync_emitter.sv
// sync_emitter: framed optical sync-pulse emitter with pulse-width coded skip/data/axis bits.
// Optional sweep strobe generation is built only when SYNC_EMITTER_SWEEP_EN is defined.
module sync_emitter
   import sync_emitter_pkg::*;
#(
   parameter int unsigned BASE_CYC  = 6250,
   parameter int unsigned STEP_CYC  = 1042,
   parameter int unsigned FRAME_CYC = 833333,
   parameter int unsigned SWEEP_CYC = 100
) (
   input  logic             sys_clock,
   input  logic             sys_resetn,
   input  logic             enable,
   input  logic             skip,
   input  logic [CNT_W-1:0] sweep_ofs,
   sync_emitter_if.slave    dbus,
   output logic             ir_out,
   output logic             sweep_out,
   output logic             frame_start,
   output logic             axis,
   output logic             busy
);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   code_t            r_code, w_code_nxt;
   logic             r_axis, w_axis_nxt;
   logic             r_ir, r_fs, r_busy;
   logic             w_ir_nxt, w_fs_nxt, w_busy_nxt;
   logic             w_enter, w_sync_end, w_frame_end, w_bit;

   sync_emitter_shreg u_shreg (
      .i_clk   (sys_clock),
      .i_rst_n (sys_resetn),
      .i_pop   (w_enter),
      .o_bit   (w_bit),
      .dbus    (dbus)
   );

   assign w_sync_end  = (r_state == SYNC) &&
                        (32'(r_cnt) == pulse_width(BASE_CYC, STEP_CYC, r_code) - 1);
   assign w_frame_end = (r_state == WAIT) && (32'(r_cnt) == FRAME_CYC - 1);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (enable) w_state_nxt = SYNC;
         SYNC:    if (w_sync_end) w_state_nxt = WAIT;
         WAIT:    if (w_frame_end) w_state_nxt = enable ? SYNC : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they align with the counter.
   assign w_enter    = (w_state_nxt == SYNC) && (r_state != SYNC);
   assign w_axis_nxt = r_axis ^ w_frame_end;
   assign w_code_nxt = w_enter ? {skip, w_bit, w_axis_nxt} : r_code;
   assign w_cnt_nxt  = (w_enter || (w_state_nxt == IDLE)) ? '0 : r_cnt + 1'b1;

   always_comb begin
      w_ir_nxt   = (w_state_nxt == SYNC);
      w_fs_nxt   = w_enter;
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_code  <= '0;
         r_axis  <= 1'b0;
         r_ir    <= 1'b0;
         r_fs    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_code  <= w_code_nxt;
         r_axis  <= w_axis_nxt;
         r_ir    <= w_ir_nxt;
         r_fs    <= w_fs_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign ir_out      = r_ir;
   assign frame_start = r_fs;
   assign busy        = r_busy;
   assign axis        = r_axis;

`ifdef SYNC_EMITTER_SWEEP_EN
   logic [CNT_W-1:0] r_sw_ofs, w_sw_ofs_nxt;
   logic             r_sw_en, w_sw_en_nxt;
   logic             r_sweep, w_sweep_nxt;
   int unsigned      w_sw_start;
   int unsigned      w_pw_nxt;

   assign w_sw_ofs_nxt = w_enter ? sweep_ofs : r_sw_ofs;
   assign w_sw_en_nxt  = w_enter ? ~skip : r_sw_en;
   assign w_pw_nxt     = pulse_width(BASE_CYC, STEP_CYC, w_code_nxt);

   // An offset inside the sync pulse is pushed to the first WAIT cycle.
   always_comb begin
      w_sw_start = 32'(w_sw_ofs_nxt);
      if (w_sw_start < w_pw_nxt) w_sw_start = w_pw_nxt;
   end

   assign w_sweep_nxt = (w_state_nxt == WAIT) && w_sw_en_nxt &&
                        (32'(w_cnt_nxt) >= w_sw_start) &&
                        (32'(w_cnt_nxt) < w_sw_start + SWEEP_CYC);

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         r_sw_ofs <= '0;
         r_sw_en  <= 1'b0;
         r_sweep  <= 1'b0;
      end else begin
         r_sw_ofs <= w_sw_ofs_nxt;
         r_sw_en  <= w_sw_en_nxt;
         r_sweep  <= w_sweep_nxt;
      end
   end

   assign sweep_out = r_sweep;
`else
   logic w_unused_sweep;
   assign w_unused_sweep = (^sweep_ofs) ^ (SWEEP_CYC != 0);
   assign sweep_out      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_emitter.sv
// tb_sync_emitter: directed frame-level checks of sync widths, sweep strobe, handshake and reset.
`timescale 1ns/1ps
module tb_sync_emitter;
   import sync_emitter_pkg::*;

   localparam int unsigned BASE  = 10;
   localparam int unsigned STEP  = 2;
   localparam int unsigned FRAME = 200;
   localparam int unsigned SWP   = 4;
`ifdef SYNC_EMITTER_SWEEP_EN
   localparam int SW_ON = 1;
`else
   localparam int SW_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic        skip = 1'b0;
   logic [19:0] ofs = '0;
   logic        ir_out, sweep_out, frame_start, axis, busy;

   sync_emitter_if dbus();

   sync_emitter #(
      .BASE_CYC  (BASE),
      .STEP_CYC  (STEP),
      .FRAME_CYC (FRAME),
      .SWEEP_CYC (SWP)
   ) dut (
      .sys_clock   (clk),
      .sys_resetn  (rstn),
      .enable      (enable),
      .skip        (skip),
      .sweep_ofs   (ofs),
      .dbus        (dbus),
      .ir_out      (ir_out),
      .sweep_out   (sweep_out),
      .frame_start (frame_start),
      .axis        (axis),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   int m_w, m_first, m_cnt, m_axis, m_len, m_ready;

   // Waits for a frame start, then profiles that frame until the next start or idle.
   task automatic measure(input string tag, input int act_k, input logic a_en,
                          input logic a_skip, input logic [19:0] a_ofs);
      int t = 0;
      while (frame_start !== 1'b1 && t < 600) begin
         @(negedge clk);
         t++;
      end
      check({tag, ".start"}, int'(frame_start), 1);
      m_w = 0; m_first = -1; m_cnt = 0; m_len = 0;
      m_axis  = int'(axis);
      m_ready = int'(dbus.data_ready);
      for (int k = 0; k < 600; k++) begin
         if (k > 0 && (frame_start || !busy)) break;
         if (ir_out) m_w++;
         if (sweep_out) begin
            if (m_first < 0) m_first = k;
            m_cnt++;
         end
         if (k == act_k) begin
            enable = a_en;
            skip   = a_skip;
            ofs    = a_ofs;
         end
         m_len = k + 1;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0; enable = 1'b0; skip = 1'b0; ofs = '0;
      dbus.data_valid = 1'b0; dbus.data_in = '0;
      repeat (3) @(negedge clk);
      check("rst.ir",    int'(ir_out), 0);
      check("rst.sweep", int'(sweep_out), 0);
      check("rst.fs",    int'(frame_start), 0);
      check("rst.busy",  int'(busy), 0);
      check("rst.axis",  int'(axis), 0);
      check("rst.ready", int'(dbus.data_ready), 1);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_byte(input logic [7:0] b);
      int t = 0;
      dbus.data_in = b;
      dbus.data_valid = 1'b1;
      while (dbus.data_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      dbus.data_valid = 1'b0;
      check("load.ready_low", int'(dbus.data_ready), 0);
   endtask

   int a5_w [8] = '{14, 12, 14, 12, 10, 16, 10, 16};
   int a5_r [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

   initial begin
      int fs_seen;

      // Free-running frames, sweep offsets 50 and 198, then enable drop at cycle 30.
      do_reset();
      ofs = 20'd50; enable = 1'b1;
      measure("A0", 100, 1'b1, 1'b0, 20'd198);
      check("A0.w", m_w, 10);
      check("A0.axis", m_axis, 0);
      check("A0.len", m_len, 200);
      check("A0.swfirst", m_first, SW_ON ? 50 : -1);
      check("A0.swcnt", m_cnt, SW_ON ? 4 : 0);
      measure("A1", 100, 1'b1, 1'b1, 20'd198);
      check("A1.w", m_w, 12);
      check("A1.axis", m_axis, 1);
      check("A1.len", m_len, 200);
      check("A1.swfirst", m_first, SW_ON ? 198 : -1);
      check("A1.swcnt", m_cnt, SW_ON ? 2 : 0);
      measure("A2", 30, 1'b0, 1'b1, 20'd198);
      check("A2.w", m_w, 18);
      check("A2.axis", m_axis, 0);
      check("A2.len", m_len, 200);
      check("A2.swcnt", m_cnt, 0);
      fs_seen = 0;
      for (int i = 0; i < 60; i++) begin
         if (frame_start) fs_seen++;
         @(negedge clk);
      end
      check("A.idle_fs", fs_seen, 0);
      check("A.idle_busy", int'(busy), 0);

      // Byte 0xA5 shifted out MSB first, sweep offset inside the pulse, then underrun.
      do_reset();
      load_byte(8'hA5);
      ofs = 20'd5; skip = 1'b0; enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         measure($sformatf("B%0d", i), -1, 1'b1, 1'b0, 20'd5);
         check($sformatf("B%0d.w", i), m_w, a5_w[i]);
         check($sformatf("B%0d.axis", i), m_axis, i % 2);
         check($sformatf("B%0d.ready", i), m_ready, a5_r[i]);
         check($sformatf("B%0d.swfirst", i), m_first, SW_ON ? a5_w[i] : -1);
         check($sformatf("B%0d.swcnt", i), m_cnt, SW_ON ? 4 : 0);
      end
      measure("B8", -1, 1'b1, 1'b0, 20'd5);
      check("B8.w_underrun", m_w, 10);
      check("B8.ready", m_ready, 1);

      // Skip frames with data 1, then reset mid-sync and restart.
      do_reset();
      load_byte(8'hFF);
      skip = 1'b1; ofs = 20'd50; enable = 1'b1;
      measure("C0", -1, 1'b1, 1'b1, 20'd50);
      check("C0.w", m_w, 22);
      check("C0.swcnt", m_cnt, 0);
      measure("C1", -1, 1'b1, 1'b1, 20'd50);
      check("C1.w", m_w, 24);
      check("C1.axis", m_axis, 1);
      check("C1.swcnt", m_cnt, 0);
      check("C2.ir_on", int'(ir_out), 1);
      #2 rstn = 1'b0;
      #1;
      check("C.rst_ir", int'(ir_out), 0);
      check("C.rst_busy", int'(busy), 0);
      check("C.rst_axis", int'(axis), 0);
      check("C.rst_ready", int'(dbus.data_ready), 1);
      @(negedge clk);
      rstn = 1'b1;
      measure("C3", -1, 1'b1, 1'b1, 20'd50);
      check("C3.w", m_w, 18);
      check("C3.axis", m_axis, 0);
      check("C3.ready", m_ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
